// File: rtl/bcnn_pkg.sv
// Shared types and constants for the binary convolution sequencer.
// Holds the FSM state encoding, datapath widths and the majority threshold helper.
package bcnn_pkg;

   localparam int unsigned ADDR_WIDTH = 12;
   localparam int unsigned DATA_WIDTH = 16;
   localparam int unsigned MAX_K      = 5;
   localparam int unsigned DIM_W      = 5;
   localparam int unsigned IDX_W      = $clog2(MAX_K + 1);
   localparam int unsigned POP_W      = $clog2(MAX_K * MAX_K + 1);

   typedef enum logic [2:0] {
      IDLE, RD_DIM, LD_W, LD_ROWS, COMP, WR, DONE
   } state_t;

   // Majority threshold: an output bit is set when at least half the window agrees.
   function automatic logic [POP_W-1:0] pop_threshold(input logic [DIM_W-1:0] k);
      return POP_W'((32'(k) * 32'(k) + 32'd1) / 32'd2);
   endfunction

endpackage

// File: rtl/bcnn_window_popcount.sv
// Combinational XNOR-popcount of the K x K window whose left edge is column i_col.
// Rows and kernel entries beyond K are masked out.
module bcnn_window_popcount
   import bcnn_pkg::*;
(
   input  logic [MAX_K*DATA_WIDTH-1:0] i_x_rows,
   input  logic [MAX_K*MAX_K-1:0]      i_w_rows,
   input  logic [DIM_W-1:0]            i_col,
   input  logic [DIM_W-1:0]            i_k,
   output logic [POP_W-1:0]            o_pop_c
);

   logic [DATA_WIDTH-1:0] w_xs;
   logic [MAX_K-1:0]      w_ws;

   always_comb begin
      o_pop_c = '0;
      w_xs    = '0;
      w_ws    = '0;
      for (int i = 0; i < int'(MAX_K); i++) begin
         w_xs = i_x_rows[i*DATA_WIDTH +: DATA_WIDTH] >> i_col;
         w_ws = i_w_rows[i*MAX_K +: MAX_K];
         for (int j = 0; j < int'(MAX_K); j++) begin
            if (i < int'(i_k) && j < int'(i_k)) begin
               o_pop_c = o_pop_c + POP_W'(w_xs[j] == w_ws[j]);
            end
         end
      end
   end

endmodule

// File: rtl/bcnn_conv_sequencer.sv
// Run/busy controller for one binary convolution layer: loads N, K, the kernel and a
// sliding K-row window from SRAM, computes one output row per window and writes it back.
module bcnn_conv_sequencer
   import bcnn_pkg::*;
#(
   parameter logic [ADDR_WIDTH-1:0] IN_BASE  = 12'h000,
   parameter logic [ADDR_WIDTH-1:0] W_BASE   = 12'h000,
   parameter logic [ADDR_WIDTH-1:0] OUT_BASE = 12'h000
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  dut_run,
   output logic                  dut_busy,
   output logic [ADDR_WIDTH-1:0] dut_sram_read_address,
   input  logic [DATA_WIDTH-1:0] sram_dut_read_data,
   output logic [ADDR_WIDTH-1:0] dut_wmem_read_address,
   input  logic [DATA_WIDTH-1:0] wmem_dut_read_data,
   output logic                  dut_sram_write_enable,
   output logic [ADDR_WIDTH-1:0] dut_sram_write_address,
   output logic [DATA_WIDTH-1:0] dut_sram_write_data,
   output logic                  cfg_error
);

   state_t                r_state, w_next_state;
   logic [IDX_W-1:0]      r_idx;
   logic [DIM_W-1:0]      r_col, r_row, r_k, r_m;
   logic [DATA_WIDTH-1:0] r_xreg [MAX_K];
   logic [MAX_K-1:0]      r_wreg [MAX_K];
   logic [DATA_WIDTH-1:0] r_out;
   logic                  r_cfg_error, r_busy, r_we;
   logic [ADDR_WIDTH-1:0] r_in_addr, r_w_addr, r_wr_addr;
   logic [DATA_WIDTH-1:0] r_wr_data;

   logic                  w_busy, w_we;
   logic [ADDR_WIDTH-1:0] w_in_addr, w_w_addr, w_wr_addr;
   logic [DATA_WIDTH-1:0] w_wr_data, w_row_bits;
   logic [DIM_W-1:0]      w_n, w_k;
   logic                  w_dim_bad, w_idx_last, w_idx_more, w_col_last, w_row_last;
   logic [MAX_K*DATA_WIDTH-1:0] w_xflat;
   logic [MAX_K*MAX_K-1:0]      w_wflat;
   logic [POP_W-1:0]      w_pop;
   logic                  w_unused_wbits;

   assign w_n            = sram_dut_read_data[DIM_W-1:0];
   assign w_k            = wmem_dut_read_data[DIM_W-1:0];
   assign w_unused_wbits = ^wmem_dut_read_data[DATA_WIDTH-1:MAX_K];
   assign w_dim_bad      = (w_k == '0) || (w_k > DIM_W'(MAX_K)) ||
                           (w_n > DIM_W'(DATA_WIDTH)) || (w_n < w_k);
   assign w_idx_last     = (DIM_W'(r_idx) == r_k);
   assign w_idx_more     = ((DIM_W'(r_idx) + DIM_W'(1)) < r_k);
   assign w_col_last     = (r_col == r_m - DIM_W'(1));
   assign w_row_last     = (r_row == r_m - DIM_W'(1));

   for (genvar g = 0; g < int'(MAX_K); g++) begin : g_flat
      assign w_xflat[g*DATA_WIDTH +: DATA_WIDTH] = r_xreg[g];
      assign w_wflat[g*MAX_K +: MAX_K]           = r_wreg[g];
   end

   bcnn_window_popcount u_pop (
      .i_x_rows (w_xflat),
      .i_w_rows (w_wflat),
      .i_col    (r_col),
      .i_k      (r_k),
      .o_pop_c  (w_pop)
   );

   always_ff @(posedge clk) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:    if (dut_run) w_next_state = RD_DIM;
         RD_DIM:  if (r_idx != '0) w_next_state = w_dim_bad ? DONE : LD_W;
         LD_W:    if (w_idx_last) w_next_state = LD_ROWS;
         LD_ROWS: if (w_idx_last) w_next_state = COMP;
         COMP:    if (w_col_last) w_next_state = WR;
         WR:      w_next_state = w_row_last ? DONE : LD_ROWS;
         DONE:    w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   // Next values of the registered outputs; read addresses are set one cycle ahead of use.
   always_comb begin
      w_busy     = (w_next_state != IDLE);
      w_we       = (w_next_state == WR);
      w_in_addr  = r_in_addr;
      w_w_addr   = r_w_addr;
      w_wr_addr  = r_wr_addr;
      w_wr_data  = r_wr_data;
      w_row_bits = r_out;
      case (r_state)
         IDLE: begin
            if (dut_run) begin
               w_in_addr = IN_BASE;
               w_w_addr  = W_BASE;
            end
         end
         RD_DIM: if (r_idx != '0) w_w_addr = W_BASE + ADDR_WIDTH'(1);
         LD_W: begin
            if (w_idx_more) w_w_addr = W_BASE + ADDR_WIDTH'(r_idx) + ADDR_WIDTH'(2);
            if (w_idx_last) w_in_addr = IN_BASE + ADDR_WIDTH'(r_row) + ADDR_WIDTH'(1);
         end
         LD_ROWS: begin
            if (w_idx_more)
               w_in_addr = IN_BASE + ADDR_WIDTH'(r_row) + ADDR_WIDTH'(r_idx) + ADDR_WIDTH'(2);
         end
         COMP: begin
            w_row_bits[r_col[3:0]] = (w_pop >= pop_threshold(r_k));
            if (w_col_last) begin
               w_wr_addr = OUT_BASE + ADDR_WIDTH'(r_row);
               w_wr_data = w_row_bits;
            end
         end
         WR: if (!w_row_last) w_in_addr = IN_BASE + ADDR_WIDTH'(r_row) + ADDR_WIDTH'(2);
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_idx       <= '0;
         r_col       <= '0;
         r_row       <= '0;
         r_k         <= '0;
         r_m         <= '0;
         r_out       <= '0;
         r_cfg_error <= 1'b0;
         r_busy      <= 1'b0;
         r_we        <= 1'b0;
         r_in_addr   <= '0;
         r_w_addr    <= '0;
         r_wr_addr   <= '0;
         r_wr_data   <= '0;
         for (int i = 0; i < int'(MAX_K); i++) begin
            r_xreg[i] <= '0;
            r_wreg[i] <= '0;
         end
      end else begin
         r_busy    <= w_busy;
         r_we      <= w_we;
         r_in_addr <= w_in_addr;
         r_w_addr  <= w_w_addr;
         r_wr_addr <= w_wr_addr;
         r_wr_data <= w_wr_data;
         case (r_state)
            IDLE: begin
               if (dut_run) begin
                  r_idx       <= '0;
                  r_cfg_error <= 1'b0;
               end
            end
            RD_DIM: begin
               if (r_idx == '0) begin
                  r_idx <= IDX_W'(1);
               end else begin
                  r_idx       <= '0;
                  r_row       <= '0;
                  r_k         <= w_k;
                  r_m         <= w_n - w_k + DIM_W'(1);
                  r_cfg_error <= w_dim_bad;
               end
            end
            LD_W: begin
               if (r_idx != '0) r_wreg[r_idx - IDX_W'(1)] <= wmem_dut_read_data[MAX_K-1:0];
               r_idx <= w_idx_last ? '0 : r_idx + IDX_W'(1);
            end
            LD_ROWS: begin
               r_out <= '0;
               r_col <= '0;
               if (r_idx != '0) r_xreg[r_idx - IDX_W'(1)] <= sram_dut_read_data;
               r_idx <= w_idx_last ? '0 : r_idx + IDX_W'(1);
            end
            COMP: begin
               r_out <= w_row_bits;
               r_col <= r_col + DIM_W'(1);
            end
            WR: if (!w_row_last) r_row <= r_row + DIM_W'(1);
            default: ;
         endcase
      end
   end

   assign dut_busy               = r_busy;
   assign dut_sram_read_address  = r_in_addr;
   assign dut_wmem_read_address  = r_w_addr;
   assign dut_sram_write_enable  = r_we;
   assign dut_sram_write_address = r_wr_addr;
   assign dut_sram_write_data    = r_wr_data;
   assign cfg_error              = r_cfg_error;

endmodule

// File: tb/tb_bcnn_conv_sequencer.sv
// Scoreboard bench for bcnn_conv_sequencer: directed layer runs push expected output
// writes into a queue, and a negedge monitor pops and compares every write strobe.
module tb_bcnn_conv_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        dut_run;
   logic        dut_busy;
   logic [11:0] dut_sram_read_address;
   logic [15:0] sram_dut_read_data;
   logic [11:0] dut_wmem_read_address;
   logic [15:0] wmem_dut_read_data;
   logic        dut_sram_write_enable;
   logic [11:0] dut_sram_write_address;
   logic [15:0] dut_sram_write_data;
   logic        cfg_error;

   logic [15:0] in_mem [64];
   logic [15:0] w_mem  [64];
   logic [27:0] exp_q [$];
   int          n_checks = 0;
   int          n_pass   = 0;
   int          wr_count = 0;

   always #5 clk = ~clk;

   bcnn_conv_sequencer dut (
      .clk                    (clk),
      .reset                  (reset),
      .dut_run                (dut_run),
      .dut_busy               (dut_busy),
      .dut_sram_read_address  (dut_sram_read_address),
      .sram_dut_read_data     (sram_dut_read_data),
      .dut_wmem_read_address  (dut_wmem_read_address),
      .wmem_dut_read_data     (wmem_dut_read_data),
      .dut_sram_write_enable  (dut_sram_write_enable),
      .dut_sram_write_address (dut_sram_write_address),
      .dut_sram_write_data    (dut_sram_write_data),
      .cfg_error              (cfg_error)
   );

   // Synchronous-read SRAMs: data appears the cycle after the address.
   always @(posedge clk) begin
      sram_dut_read_data <= in_mem[dut_sram_read_address[5:0]];
      wmem_dut_read_data <= w_mem[dut_wmem_read_address[5:0]];
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   always @(negedge clk) begin
      if (dut_sram_write_enable) begin
         wr_count++;
         if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_write: got addr %h data %h expected no write",
                     dut_sram_write_address, dut_sram_write_data);
         end else begin
            check("write", {4'h0, dut_sram_write_address, dut_sram_write_data},
                  {4'h0, exp_q.pop_front()});
         end
      end
   end

   function automatic int run_cycles(input int n, input int k);
      int m = n - k + 1;
      return 2 + (k + 1) + m * ((k + 1) + m + 1) + 1;
   endfunction

   // Independent golden model for one output row.
   function automatic logic [15:0] model_row(input int r, input int n, input int k);
      logic [15:0] res = '0;
      logic [15:0] xw, ww;
      int pop;
      for (int c = 0; c < n - k + 1; c++) begin
         pop = 0;
         for (int i = 0; i < k; i++) begin
            xw = in_mem[1 + r + i];
            ww = w_mem[1 + i];
            for (int j = 0; j < k; j++) if (xw[c + j] == ww[j]) pop++;
         end
         res[c] = (pop >= (k * k + 1) / 2);
      end
      return res;
   endfunction

   task automatic load_uniform(input int n, input int k, input logic [15:0] x, input logic [15:0] w);
      in_mem[0] = 16'(n);
      w_mem[0]  = 16'(k);
      for (int i = 1; i <= 16; i++) in_mem[i] = x;
      for (int i = 1; i <= 5; i++) w_mem[i] = w;
   endtask

   task automatic push(input logic [11:0] a, input logic [15:0] d);
      exp_q.push_back({a, d});
   endtask

   task automatic do_run(input string name, input int exp_cyc, input logic exp_err,
                         input int exp_wr, input bit toggle);
      int cnt = 0;
      int guard = 0;
      int wr0 = wr_count;
      @(negedge clk);
      dut_run = 1'b1;
      @(negedge clk);
      while (!dut_busy && guard < 10) begin
         @(negedge clk);
         guard++;
      end
      while (dut_busy && cnt < 2000) begin
         dut_run = toggle && (cnt < 10) && cnt[0];
         cnt++;
         @(negedge clk);
      end
      dut_run = 1'b0;
      check({name, "_busy_cycles"}, 32'(cnt), 32'(exp_cyc));
      check({name, "_cfg_error"}, 32'(cfg_error), 32'(exp_err));
      check({name, "_write_count"}, 32'(wr_count - wr0), 32'(exp_wr));
      check({name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      int cnt, wr0;
      for (int i = 0; i < 64; i++) begin
         in_mem[i] = '0;
         w_mem[i]  = '0;
      end
      reset   = 1'b1;
      dut_run = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_busy", 32'(dut_busy), 32'd0);
      check("reset_we", 32'(dut_sram_write_enable), 32'd0);
      check("reset_rd_addr", 32'(dut_sram_read_address), 32'd0);
      check("reset_w_addr", 32'(dut_wmem_read_address), 32'd0);
      check("reset_wr_addr_data", {4'h0, dut_sram_write_address, dut_sram_write_data}, 32'd0);
      check("reset_cfg_error", 32'(cfg_error), 32'd0);
      reset = 1'b0;

      // All-ones window against all-ones kernel.
      load_uniform(4, 3, 16'h000F, 16'h0007);
      push(12'h000, 16'h0003);
      push(12'h001, 16'h0003);
      do_run("t1", run_cycles(4, 3), 1'b0, 2, 1'b0);

      load_uniform(4, 3, 16'h0000, 16'h0007);
      push(12'h000, 16'h0000);
      push(12'h001, 16'h0000);
      do_run("t2_zero_in", run_cycles(4, 3), 1'b0, 2, 1'b0);

      load_uniform(4, 3, 16'h000F, 16'h0000);
      push(12'h000, 16'h0000);
      push(12'h001, 16'h0000);
      do_run("t2_zero_w", run_cycles(4, 3), 1'b0, 2, 1'b0);

      // Checkerboard against an X-shaped kernel.
      load_uniform(5, 3, 16'h0000, 16'h0000);
      in_mem[1] = 16'h0015; in_mem[2] = 16'h000A; in_mem[3] = 16'h0015;
      in_mem[4] = 16'h000A; in_mem[5] = 16'h0015;
      w_mem[1] = 16'h0005; w_mem[2] = 16'h0002; w_mem[3] = 16'h0005;
      for (int r = 0; r < 3; r++) push(12'(r), model_row(r, 5, 3));
      do_run("t3_checker", run_cycles(5, 3), 1'b0, 3, 1'b0);

      // Illegal dimensions: two-cycle dimension read then DONE.
      load_uniform(4, 0, 16'h000F, 16'h0007);
      do_run("t4_k0", 3, 1'b1, 0, 1'b0);
      load_uniform(2, 3, 16'h000F, 16'h0007);
      do_run("t4_n_lt_k", 3, 1'b1, 0, 1'b0);
      load_uniform(4, 3, 16'h000F, 16'h0007);
      push(12'h000, 16'h0003);
      push(12'h001, 16'h0003);
      do_run("t4_recover", run_cycles(4, 3), 1'b0, 2, 1'b0);

      // Reset in the first COMP cycle of row 1 (busy cycle 18).
      push(12'h000, 16'h0003);
      wr0 = wr_count;
      @(negedge clk);
      dut_run = 1'b1;
      @(negedge clk);
      dut_run = 1'b0;
      cnt = 1;
      while (dut_busy && cnt < 18) begin
         cnt++;
         @(negedge clk);
      end
      check("t5_reached_comp", 32'(cnt), 32'd18);
      reset = 1'b1;
      @(negedge clk);
      check("t5_busy_after_reset", 32'(dut_busy), 32'd0);
      check("t5_we_after_reset", 32'(dut_sram_write_enable), 32'd0);
      reset = 1'b0;
      repeat (10) @(negedge clk);
      check("t5_no_more_writes", 32'(wr_count - wr0), 32'd1);
      check("t5_still_idle", 32'(dut_busy), 32'd0);
      push(12'h000, 16'h0003);
      push(12'h001, 16'h0003);
      do_run("t5_rerun", run_cycles(4, 3), 1'b0, 2, 1'b0);

      // Run held high: relaunches after one IDLE cycle.
      push(12'h000, 16'h0003);
      push(12'h001, 16'h0003);
      push(12'h000, 16'h0003);
      push(12'h001, 16'h0003);
      wr0 = wr_count;
      @(negedge clk);
      dut_run = 1'b1;
      @(negedge clk);
      cnt = 0;
      while (dut_busy && cnt < 2000) begin
         cnt++;
         @(negedge clk);
      end
      check("t6_first_cycles", 32'(cnt), 32'(run_cycles(4, 3)));
      check("t6_idle_gap", 32'(dut_busy), 32'd0);
      @(negedge clk);
      check("t6_relaunch", 32'(dut_busy), 32'd1);
      dut_run = 1'b0;
      cnt = 0;
      while (dut_busy && cnt < 2000) begin
         cnt++;
         @(negedge clk);
      end
      check("t6_second_cycles", 32'(cnt), 32'(run_cycles(4, 3)));
      check("t6_write_count", 32'(wr_count - wr0), 32'd4);

      push(12'h000, 16'h0003);
      push(12'h001, 16'h0003);
      do_run("t6_toggle", run_cycles(4, 3), 1'b0, 2, 1'b1);

      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
